mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data bus, in parallel with dmem.
- Decodes the core's store address, buffers written bytes in a FIFO and serialises them as 8N1 on a single pin.
- Lets the running program print debug and status text without using the LED-only output.
- Returns a status word on reads from its address window. The top level muxes this word into ReadData in place of dmem data.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 8-byte register window.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be at least 2.
- FIFO_DEPTH, 16, byte entries in the TX FIFO. Power of two, at least 2.

Ports:
- clk  in  1  system clock (single domain)
- reset  in  1  synchronous, active-high reset
- we  in  1  store strobe from core (MemWrite)
- a  in  32  data address from core (ALUResult)
- wd  in  32  store data from core (WriteData)
- rd  out  32  combinational read data when the address is in the window; 0 otherwise
- sel  out  1  combinational: high when a[31:3] == BASE_ADDR[31:3]; top uses it to mux rd over dmem data
- tx  out  1  UART serial output, registered, idle high
- irq_empty  out  1  registered: high when FIFO is empty and FSM is IDLE (all text drained)

Behaviour:
- Register map (byte offset from BASE_ADDR; a[1:0] ignored):
  - 0x0 TXDATA, write-only. A write pushes wd[7:0]. Reads return 0.
  - 0x4 STATUS, read/write.
    - Read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[12:8] FIFO count, all other bits 0.
    - Write: wd[3]=1 clears overflow. All other bits are ignored.
- A write is any cycle with we=1 and sel=1. It takes effect at the rising edge of that cycle. There is no wait state; the core never stalls.
- Push rule: a TXDATA write while full is dropped and sets overflow at the same edge.
  - Exception: if the FSM pops on that same edge, the push is accepted and overflow is not set.
  - Count never exceeds FIFO_DEPTH and never goes below 0.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1; a bit index counts 0..7.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START at the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: a TXDATA write sampled at edge E0 into an empty FIFO with the FSM in IDLE:
  - E1: FSM pops and enters START; tx=0 from E1.
  - The frame lasts exactly 10*CLKS_PER_BIT cycles from E1.
- Frame content is fixed at pop time. Later writes do not alter a frame in flight.
- Reset, including mid-frame, takes effect at the next edge:
  - FSM goes to IDLE, tx=1, FIFO is emptied (count 0).
  - overflow=0, baud counter and bit index = 0, shift register = 0, irq_empty=1.
  - rd and sel stay purely combinational from a.
- Writes to unmapped offsets inside the window (none exist at an 8-byte window) and reads of TXDATA have no side effects.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - register offset constants TXDATA_OFS=3'h0 and STATUS_OFS=3'h4
  - STATUS bit index constants (FULL=0, EMPTY=1, BUSY=2, OVF=3, CNT_LSB=8)
- Sub-module sync_fifo, parameterised for width and depth:
  - write/read pointers plus count, with full, empty and count outputs
  - synchronous reset; simultaneous push and pop allowed when full or empty per the push rule above
- The top of this block holds the decode, the status/overflow logic and the TX FSM.

Test Plan:
- Single byte (CLKS_PER_BIT=4): write 0x55 to BASE+0 at E0.
  - tx=0 for cycles E1..E1+3, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop=1.
  - Total 40 cycles; then irq_empty=1.
- Back-to-back: write 0x41, 0x42, 0x43 on three consecutive cycles.
  - Three frames with no idle cycle between stop and the next start.
  - STATUS count reads 2 right after the first pop.
- Overflow (FIFO_DEPTH=4): with the FSM busy, write 6 bytes.
  - STATUS reads full=1, overflow=1, count=4.
  - Only the first 5 bytes are transmitted: 1 in flight plus 4 buffered.
  - Writing STATUS with wd=32'h8 clears overflow and leaves count unchanged.
- Push-on-pop: with the FIFO full, issue a write on the exact edge the FSM pops.
  - The byte is accepted, count stays 4 and overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued.
  - tx=1 at the next edge; STATUS reads 32'h0000_0002 (empty=1).
  - Nothing is transmitted afterwards.
- Decode: access a = BASE_ADDR+8 and a = BASE_ADDR-4.
  - sel=0 and rd=0 for both; a write with we=1 at these addresses leaves FIFO count unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and register map constants for the MMIO UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;
  localparam int FULL = 0;
  localparam int EMPTY = 1;
  localparam int BUSY = 2;
  localparam int OVF = 3;
  localparam int CNT_LSB = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only when a pop frees a slot on the same edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk) if (do_push) mem_q[wptr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and status register
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        irq_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d;
  logic f_full, f_empty, pop, push_ok, baud_end, wr_tx, wr_st, st_hit, tx_hit;
  logic [7:0] f_data;
  logic [CW-1:0] f_cnt, cnt_nxt;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{wd[31:8], a[1:0]};
  assign sel = a[31:3] == BASE_ADDR[31:3];
  assign st_hit = {a[2], 2'b00} == STATUS_OFS;
  assign tx_hit = {a[2], 2'b00} == TXDATA_OFS;
  assign wr_tx = we & sel & tx_hit;
  assign wr_st = we & sel & st_hit;
  assign push_ok = wr_tx & (~f_full | pop);
  assign cnt_nxt = f_cnt + CW'(push_ok) - CW'(pop);
  assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
  assign rd = sel && st_hit ? status : '0;
  assign tx = tx_q;
  assign irq_empty = irq_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .pop(pop), .wdata(wd[7:0]),
    .rdata(f_data), .full(f_full), .empty(f_empty), .count(f_cnt)
  );
  always_comb begin
    status = '0;
    status[FULL] = f_full;
    status[EMPTY] = f_empty;
    status[BUSY] = state_q != IDLE;
    status[OVF] = ovf_q;
    status[CNT_LSB +: CW] = f_cnt;
  end
  // A full-FIFO write only overflows when the FSM is not popping on the same edge
  assign ovf_d = wr_st && wd[OVF] ? 1'b0 : wr_tx && f_full && !pop ? 1'b1 : ovf_q;
  always_comb begin
    state_d = state_q;
    baud_d = baud_q;
    idx_d = idx_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!f_empty) begin
        pop = 1'b1;
        shift_d = f_data;
        baud_d = '0;
        state_d = START;
      end
      START: if (baud_end) begin
        baud_d = '0;
        idx_d = '0;
        state_d = DATA;
      end else baud_d = baud_q + BW'(1);
      DATA: if (baud_end) begin
        baud_d = '0;
        shift_d = {1'b0, shift_q[7:1]};
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end else baud_d = baud_q + BW'(1);
      STOP: if (baud_end) begin
        baud_d = '0;
        pop = !f_empty;
        shift_d = f_empty ? shift_q : f_data;
        state_d = f_empty ? IDLE : START;
      end else baud_d = baud_q + BW'(1);
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    irq_d = cnt_nxt == '0 && state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      irq_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      irq_q <= irq_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed checks of decode, status, FIFO overflow and 8N1 framing at 4 clocks per bit
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0;
  logic reset, we, sel, tx, irq_empty;
  logic [31:0] a, wd, rd;
  int tests = 0, fails = 0, cyc = 0, e0;
  logic txlog [0:4095];
  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .sel(sel), .tx(tx), .irq_empty(irq_empty)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 4096) txlog[cyc] = tx;
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    a = addr;
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  task automatic status_is(input string tag, input logic [31:0] exp);
    a = BASE + 32'd4;
    #1;
    chk(tag, rd, exp);
  endtask
  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask
  task automatic frame_chk(input string tag, input int s, input logic [7:0] b);
    logic [39:0] obs, exp;
    for (int k = 0; k < 40; k++) begin
      obs[k] = txlog[s + k];
      exp[k] = k < 4 ? 1'b0 : k < 36 ? b[(k - 4) / 4] : 1'b1;
    end
    chk(tag, obs, exp);
  endtask
  task automatic idle_chk(input string tag, input int s, input int n);
    int ones = 0;
    for (int k = 0; k < n; k++) ones += int'(txlog[s + k]);
    chk(tag, 40'(ones), 40'(n));
  endtask
  initial begin
    reset = 1'b1; we = 1'b0; a = '0; wd = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq_empty, 1);
    status_is("rst_status", 32'h0000_0002);
    chk("rst_sel", sel, 1);
    // single byte
    wr(BASE, 32'h55); e0 = cyc;
    chk("single_irq_low", irq_empty, 0);
    status_is("single_status_e0", 32'h0000_0100);
    tick();
    chk("single_start_e1", tx, 0);
    status_is("single_status_e1", 32'h0000_0006);
    wait_until(e0 + 42);
    frame_chk("single_frame", e0 + 1, 8'h55);
    chk("single_idle_after", txlog[e0 + 41], 1);
    chk("single_irq_done", irq_empty, 1);
    // back-to-back
    wr(BASE, 32'h41); e0 = cyc;
    wr(BASE, 32'h42);
    wr(BASE, 32'h43);
    status_is("b2b_status", 32'h0000_0204);
    wait_until(e0 + 123);
    frame_chk("b2b_frame0", e0 + 1, 8'h41);
    frame_chk("b2b_frame1", e0 + 41, 8'h42);
    frame_chk("b2b_frame2", e0 + 81, 8'h43);
    chk("b2b_idle_after", txlog[e0 + 121], 1);
    chk("b2b_irq", irq_empty, 1);
    // overflow
    wr(BASE, 32'h10); e0 = cyc;
    for (int i = 1; i < 6; i++) wr(BASE, 32'h10 + 32'(i));
    status_is("ovf_status", 32'h0000_040D);
    wr(BASE + 32'd4, 32'h8);
    status_is("ovf_cleared", 32'h0000_0405);
    wait_until(e0 + 203);
    for (int i = 0; i < 5; i++) frame_chk($sformatf("ovf_frame%0d", i), e0 + 1 + 40 * i, 8'h10 + 8'(i));
    chk("ovf_no_sixth", txlog[e0 + 201], 1);
    chk("ovf_irq", irq_empty, 1);
    // push on the pop edge
    wr(BASE, 32'h20); e0 = cyc;
    for (int i = 1; i < 5; i++) wr(BASE, 32'h20 + 32'(i));
    status_is("pop_full", 32'h0000_0405);
    wait_until(e0 + 40);
    wr(BASE, 32'h25);
    status_is("pop_push_status", 32'h0000_0405);
    wait_until(e0 + 243);
    for (int i = 0; i < 6; i++) frame_chk($sformatf("pop_frame%0d", i), e0 + 1 + 40 * i, 8'h20 + 8'(i));
    chk("pop_idle_after", txlog[e0 + 241], 1);
    // reset mid-frame during data bit 3
    wr(BASE, 32'h30); e0 = cyc;
    wr(BASE, 32'h31);
    wr(BASE, 32'h32);
    wait_until(e0 + 18);
    chk("rstmid_bit3", tx, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_irq", irq_empty, 1);
    status_is("rstmid_status", 32'h0000_0002);
    wait_until(e0 + 121);
    idle_chk("rstmid_silent", e0 + 19, 100);
    // decode
    a = BASE + 32'd8; #1;
    chk("dec_hi_sel", sel, 0);
    chk("dec_hi_rd", rd, 0);
    a = BASE - 32'd4; #1;
    chk("dec_lo_sel", sel, 0);
    chk("dec_lo_rd", rd, 0);
    a = BASE; #1;
    chk("dec_txdata_rd", rd, 0);
    a = BASE + 32'd6; #1;
    chk("dec_status_alias", rd, 32'h0000_0002);
    wr(BASE + 32'd8, 32'hAB); e0 = cyc;
    wr(BASE - 32'd4, 32'hCD);
    status_is("dec_count", 32'h0000_0002);
    chk("dec_irq", irq_empty, 1);
    wait_until(e0 + 12);
    idle_chk("dec_silent", e0, 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
